servo_ramp_sequencer: RTL

SERVO_RAMP_SEQUENCER -- requirements
Module: servo_ramp_sequencer

---
 rtl/servo_ramp_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/servo_ramp_sequencer.sv
// Servo compare-value ramp sequencer.
// Accepts a target position through a valid/ready handshake and clamps it to the
// legal range. On each PWM period tick it moves the PWM compare value by at most
// STEP toward the target, then pulses done for one cycle. abort freezes the ramp
// and returns to IDLE without a done pulse.
module servo_ramp_sequencer #(
   parameter int WIDTH     = 12,
   parameter int STEP      = 4,
   parameter int RESET_POS = 1536,
   parameter int MIN_POS   = 256,
   parameter int MAX_POS   = 3840
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic             period_tick,
   input  logic             abort,
   output logic [WIDTH-1:0] compare,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RAMP = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_POS);
   localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_POS);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_POS);
   localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
   localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);

   logic [1:0]       state;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] clamped;
   logic [WIDTH:0]   diff;
   logic             near;
   logic             move_up;

   // Clamp the incoming request and measure the remaining distance to target.
   always_comb begin
      clamped = tgt_data;
      if (tgt_data < MIN_V)
         clamped = MIN_V;
      else if (tgt_data > MAX_V)
         clamped = MAX_V;

      move_up = (target > compare);
      if (move_up)
         diff = {1'b0, target} - {1'b0, compare};
      else
         diff = {1'b0, compare} - {1'b0, target};
      near = (diff <= STEP_W);
   end

   // Handshake capture, ramp stepping and state sequencing.
   // A full STEP is only taken when the distance exceeds STEP, so the stepped
   // value always stays strictly between compare and target and cannot wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         compare <= RESET_V;
         target  <= RESET_V;
      end else begin
         case (state)
            S_IDLE: begin
               if (tgt_valid) begin
                  target <= clamped;
                  state  <= S_RAMP;
               end
            end
            S_RAMP: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (period_tick) begin
                  if (near) begin
                     compare <= target;
                     state   <= S_DONE;
                  end else if (move_up) begin
                     compare <= compare + STEP_N;
                  end else begin
                     compare <= compare - STEP_N;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Status outputs decoded from state alone.
   always_comb begin
      tgt_ready = (state == S_IDLE);
      busy      = (state == S_RAMP);
      done      = (state == S_DONE);
   end

endmodule
